// File: rtl/arith_pkg.sv
// Shared constants for the serial arithmetic blocks.
//   DEFAULT_WIDTH : default operand/result width
//   IDLE/RUN/DONE : FSM state encoding shared by the serial units
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin (mod 2), with borrow-out.
//   a, b : operand bits
//   bin  : borrow-in
//   diff : difference bit
//   bout : borrow-out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_8b.sv
// Bit-serial subtractor computing a - b - bin, LSB first, one bit per clock.
//   clk, rst : clock and asynchronous active-high reset
//   start    : begin a subtraction (only accepted while ready=1)
//   a, b     : minuend / subtrahend, captured on the accepted start edge
//   bin      : borrow-in, captured on the accepted start edge
//   ready    : high in IDLE only
//   done     : one-cycle pulse when diff/bout/ovf hold a new result
//   diff     : registered difference modulo 2^WIDTH
//   bout     : registered final borrow-out
//   ovf      : registered signed overflow flag
module serial_subtractor_8b #(
    parameter int WIDTH = arith_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    import arith_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic fs_diff;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = fs_bout;
                // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                res_d  = {fs_diff, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = {fs_diff, res_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
                    // br_q is the borrow into the MSB during this last step.
                    ovf_d   = br_q ^ fs_bout;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8b.sv
// Self-checking bench for serial_subtractor_8b (WIDTH=8): directed corner cases,
// start-while-busy, mid-run reset and random operands against an arithmetic model.
module tb_serial_subtractor_8b;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       ready;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    serial_subtractor_8b #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, bout, diff}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic bi);
        int ux, uy, sx, sy, ur, sr;
        logic [7:0] d;
        ux = int'(x);
        uy = int'(y);
        sx = x[7] ? ux - 256 : ux;
        sy = y[7] ? uy - 256 : uy;
        ur = ux - uy - int'(bi);
        sr = sx - sy - int'(bi);
        d  = 8'((ur + 512) % 256);
        return {(sr < -128 || sr > 127), (ur < 0), d};
    endfunction

    // Runs one subtraction from IDLE and checks latency, handshake and result.
    // poke=1 re-pulses start with junk operands during RUN and DONE.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xbin,
                          input bit poke, input string tag);
        logic [9:0] exp;
        logic [7:0] prev_diff;
        int guard;
        exp = model(xa, xb, xbin);
        @(negedge clk);
        guard = 0;
        while (ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready_before"}, 32'(ready), 32'd1);
        a     = xa;
        b     = xb;
        bin   = xbin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operand changes after the accepted edge must not matter.
        a   = 8'($urandom);
        b   = 8'($urandom);
        bin = 1'($urandom);
        chk({tag, "_ready_run"}, 32'(ready), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i < 8) begin
                chk({tag, "_done_early"}, 32'(done), 32'd0);
                if (poke && i == 3) begin
                    start = 1'b1;
                    a     = 8'($urandom);
                    b     = 8'($urandom);
                end
                if (poke && i == 4) start = 1'b0;
            end else begin
                chk({tag, "_done"}, 32'(done), 32'd1);
                chk({tag, "_diff"}, 32'(diff), 32'(exp[7:0]));
                chk({tag, "_bout"}, 32'(bout), 32'(exp[8]));
                chk({tag, "_ovf"}, 32'(ovf), 32'(exp[9]));
                chk({tag, "_ready_done"}, 32'(ready), 32'd0);
                if (poke) begin
                    start = 1'b1;
                    a     = 8'($urandom);
                    b     = 8'($urandom);
                end
            end
        end
        prev_diff = exp[7:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(ready), 32'd1);
        chk({tag, "_diff_hold"}, 32'(diff), 32'(prev_diff));
        if (poke) begin
            @(posedge clk);
            #1;
            chk({tag, "_no_queued_op"}, 32'(ready), 32'd1);
            chk({tag, "_no_second_done"}, 32'(done), 32'd0);
            chk({tag, "_diff_kept"}, 32'(diff), 32'(prev_diff));
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rbin;
        int         done_seen;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        bin   = 1'b0;
        #2;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_bout", 32'(bout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h50, 8'h20, 1'b0, 1'b0, "p50_20");
        run_op(8'h00, 8'h01, 1'b0, 1'b0, "wrap0_1");
        run_op(8'h80, 8'h01, 1'b0, 1'b0, "ovf80_01");
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0, "ovf7f_ff");
        run_op(8'h05, 8'h05, 1'b1, 1'b0, "eq_bin");
        run_op(8'h3C, 8'h11, 1'b0, 1'b1, "busy_start");

        // Reset during RUN cycle 4: no done, outputs cleared immediately.
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h12;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h10, 8'h01, 1'b0, 1'b0, "after_rst");

        for (int n = 0; n < 20; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            run_op(ra, rb, rbin, 1'(n % 4 == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
